// File: rtl/issue_div_fifo_if.sv
// Issue-to-divide packet type and the handshake bundle between the issue stage,
// the divide FIFO and execute_div.
package issue_div_pkg;
  typedef struct packed {
    logic        enable;
    logic [5:0]  rob_id;
    logic [3:0]  div_op;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [5:0]  rd_tag;
  } issue_execute_pack_t;
endpackage

interface issue_div_fifo_if #(
  parameter int DEPTH = 16
);
  import issue_div_pkg::*;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  issue_execute_pack_t issue_div_fifo_data_in;
  logic                issue_div_fifo_push;
  logic                issue_div_fifo_full;
  issue_execute_pack_t issue_div_fifo_data_out;
  logic                issue_div_fifo_data_out_valid;
  logic                issue_div_fifo_pop;
  logic                issue_div_fifo_flush;
  logic [CNT_W-1:0]    issue_div_fifo_count;

  modport slave (
    input  issue_div_fifo_data_in,
    input  issue_div_fifo_push,
    input  issue_div_fifo_pop,
    input  issue_div_fifo_flush,
    output issue_div_fifo_full,
    output issue_div_fifo_data_out,
    output issue_div_fifo_data_out_valid,
    output issue_div_fifo_count
  );

  modport master (
    output issue_div_fifo_data_in,
    output issue_div_fifo_push,
    output issue_div_fifo_pop,
    output issue_div_fifo_flush,
    input  issue_div_fifo_full,
    input  issue_div_fifo_data_out,
    input  issue_div_fifo_data_out_valid,
    input  issue_div_fifo_count
  );
endinterface

// File: rtl/issue_div_fifo.sv
// Circular FIFO holding issued packets for execute_div; wrap-bit pointers
// distinguish full from empty, and a commit flush empties it in one cycle.
module issue_div_fifo
  import issue_div_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  issue_div_fifo_if.slave    bus
);
  localparam int IDX_W = $clog2(DEPTH);

  logic [CNT_W-1:0]    rptr_q, rptr_d;
  logic [CNT_W-1:0]    wptr_q, wptr_d;
  issue_execute_pack_t mem_q [DEPTH];

  logic empty;
  logic full;
  logic push_ok;
  logic pop_ok;

  assign empty = (rptr_q == wptr_q);
  assign full  = (rptr_q[IDX_W-1:0] == wptr_q[IDX_W-1:0]) &&
                 (rptr_q[IDX_W] != wptr_q[IDX_W]);

  // Flush outranks everything; full/empty come from the registered pointers only.
  always_comb begin
    push_ok = bus.issue_div_fifo_push && !bus.issue_div_fifo_flush && !full;
    pop_ok  = bus.issue_div_fifo_pop  && !bus.issue_div_fifo_flush && !empty;
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    if (bus.issue_div_fifo_flush) begin
      rptr_d = '0;
      wptr_d = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + CNT_W'(1);
      if (pop_ok)  rptr_d = rptr_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rptr_q <= '0;
      wptr_q <= '0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
    end
  end

  // Storage is not reset; the empty check masks stale contents.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q[IDX_W-1:0]] <= bus.issue_div_fifo_data_in;
  end

  assign bus.issue_div_fifo_full           = full;
  assign bus.issue_div_fifo_data_out_valid = !empty;
  assign bus.issue_div_fifo_count          = wptr_q - rptr_q;
  assign bus.issue_div_fifo_data_out       = empty ? '0 : mem_q[rptr_q[IDX_W-1:0]];

endmodule

// File: tb/tb_issue_div_fifo.sv
// Directed and randomized bench for issue_div_fifo against a queue-based model.
module tb_issue_div_fifo;
  import issue_div_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  issue_execute_pack_t model [$];

  always #5 clk = ~clk;

  issue_div_fifo_if #(.DEPTH(DEPTH)) bus ();

  issue_div_fifo #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic issue_execute_pack_t mk(input int rob);
    issue_execute_pack_t p;
    p.enable  = 1'b1;
    p.rob_id  = 6'(rob);
    p.div_op  = 4'($urandom);
    p.rs1_val = $urandom;
    p.rs2_val = $urandom;
    p.rd_tag  = 6'($urandom);
    return p;
  endfunction

  task automatic chk_bit(input string tag, input logic got, input logic exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    issue_execute_pack_t exp_d;
    logic [CNT_W-1:0]    exp_cnt;
    exp_d   = (model.size() != 0) ? model[0] : '0;
    exp_cnt = CNT_W'(model.size());
    vectors++;
    assert (bus.issue_div_fifo_count === exp_cnt) else begin
      miscompares++;
      $error("FAIL %s count: got %0d expected %0d", tag, bus.issue_div_fifo_count, exp_cnt);
    end
    chk_bit({tag, " valid"}, bus.issue_div_fifo_data_out_valid, model.size() != 0);
    chk_bit({tag, " full"}, bus.issue_div_fifo_full, model.size() == DEPTH);
    vectors++;
    assert (bus.issue_div_fifo_data_out === exp_d) else begin
      miscompares++;
      $error("FAIL %s data_out: got %h expected %h", tag, bus.issue_div_fifo_data_out, exp_d);
    end
  endtask

  // One clock with the given requests; the model applies the same rules at the edge.
  task automatic step(input bit push, input bit pop, input bit flush,
                      input issue_execute_pack_t d, input string tag);
    int  n;
    bit  do_push, do_pop;
    bus.issue_div_fifo_push    = push;
    bus.issue_div_fifo_pop     = pop;
    bus.issue_div_fifo_flush   = flush;
    bus.issue_div_fifo_data_in = d;
    @(posedge clk);
    n = model.size();
    if (flush) begin
      model.delete();
    end else begin
      do_push = push && (n < DEPTH);
      do_pop  = pop && (n > 0);
      if (do_pop)  void'(model.pop_front());
      if (do_push) model.push_back(d);
    end
    #1;
    bus.issue_div_fifo_push  = 1'b0;
    bus.issue_div_fifo_pop   = 1'b0;
    bus.issue_div_fifo_flush = 1'b0;
    chk_all(tag);
  endtask

  initial begin
    issue_execute_pack_t z;
    int got_rob, want_rob;
    int push_seq, pop_seq;
    z = '0;
    bus.issue_div_fifo_push    = 1'b0;
    bus.issue_div_fifo_pop     = 1'b0;
    bus.issue_div_fifo_flush   = 1'b0;
    bus.issue_div_fifo_data_in = '0;

    // Reset held two cycles, then idle
    #1;
    chk_all("in_reset");
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    step(0, 0, 0, z, "idle");
    chk_bit("idle enable", bus.issue_div_fifo_data_out.enable, 1'b0);

    // Fill, overflow, drain
    for (int i = 1; i <= 4; i++) step(1, 0, 0, mk(i), "fill");
    chk_bit("full_after_4", bus.issue_div_fifo_full, 1'b1);
    step(1, 0, 0, mk(5), "overflow_drop");
    for (int i = 1; i <= 4; i++) begin
      want_rob = i;
      got_rob  = int'(bus.issue_div_fifo_data_out.rob_id);
      vectors++;
      assert (got_rob === want_rob) else begin
        miscompares++;
        $error("FAIL drain_order: got %0d expected %0d", got_rob, want_rob);
      end
      step(0, 1, 0, z, "drain");
    end
    step(0, 1, 0, z, "pop_empty");

    // Simultaneous push/pop, non-full then full
    step(1, 0, 0, mk(1), "pp_fill");
    step(1, 0, 0, mk(2), "pp_fill");
    step(1, 1, 0, mk(3), "pp_mid");
    step(1, 0, 0, mk(4), "pp_fill");
    step(1, 0, 0, mk(5), "pp_fill");
    step(1, 1, 0, mk(9), "pp_full");
    vectors++;
    assert (bus.issue_div_fifo_count === CNT_W'(DEPTH - 1)) else begin
      miscompares++;
      $error("FAIL pp_full_count: got %0d expected %0d", bus.issue_div_fifo_count, DEPTH - 1);
    end
    while (model.size() != 0) step(0, 1, 0, z, "pp_drain");

    // Wrap-around: pointers cycle the 4-entry queue several times
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0, mk(i), "wrap_push");
      want_rob = i;
      got_rob  = int'(bus.issue_div_fifo_data_out.rob_id);
      vectors++;
      assert (got_rob === want_rob) else begin
        miscompares++;
        $error("FAIL wrap_order: got %0d expected %0d", got_rob, want_rob);
      end
      step(0, 1, 0, z, "wrap_pop");
    end

    // Flush with concurrent push and pop
    for (int i = 1; i <= 3; i++) step(1, 0, 0, mk(i), "fl_fill");
    step(1, 1, 1, mk(7), "flush");
    step(1, 0, 0, mk(8), "post_flush");
    chk_bit("post_flush_rob8", bus.issue_div_fifo_data_out.rob_id == 6'd8, 1'b1);

    // Asynchronous reset between edges
    step(1, 0, 0, mk(10), "ar_fill");
    #3 rst = 1'b0;
    model.delete();
    #1;
    chk_all("async_reset");
    @(posedge clk);
    #2 rst = 1'b1;
    step(0, 0, 0, z, "after_async");

    // Randomized traffic with occasional flush
    push_seq = 0;
    pop_seq  = 0;
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 50),
           1'($urandom_range(0, 99) < 4), mk($urandom_range(0, 63)), "rand");
    end
    while (model.size() != 0) step(0, 1, 0, z, "rand_drain");
    push_seq = push_seq + pop_seq;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1, "timeout");
  end
endmodule
